// File: rtl/nbcac_pkg.sv
// Shared definitions for the iterative NBCAC decoder:
// the FSM state type, ceiling division and the elaboration-time weight function.
package nbcac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } nbcac_dec_state_t;

  // Ceiling division for chunk-count computation.
  function automatic int nbcac_cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Weight of codeword position k (1-based) for a cw_w-bit codeword.
  // The top two weights are 2, each lower weight down to position 2 is the
  // sum of the two above it, and position 1 has weight 1. Positions outside
  // 1..cw_w weigh 0 so chunk padding contributes nothing.
  function automatic logic [63:0] nbcac_weight(input int k, input int cw_w);
    logic [63:0] w_k1;
    logic [63:0] w_k2;
    logic [63:0] w_t;
    if (k == 1) return 64'd1;
    if (k < 1 || k > cw_w) return 64'd0;
    if (k >= cw_w - 1) return 64'd2;
    w_k1 = 64'd2;
    w_k2 = 64'd2;
    for (int i = cw_w - 2; i >= k; i--) begin
      w_t  = w_k1 + w_k2;
      w_k2 = w_k1;
      w_k1 = w_t;
    end
    return w_k1;
  endfunction

endpackage

// File: rtl/nbcac_chunk_sum.sv
// Combinational weighted sum of one BPC-bit codeword chunk, modulo 2^DATA_W.
// Positions beyond CW_W (padding in the last chunk) contribute 0.
module nbcac_chunk_sum
  import nbcac_pkg::*;
#(
  parameter int CW_W   = 33,
  parameter int DATA_W = 23,
  parameter int BPC    = 4,
  localparam int NCH   = nbcac_cdiv(CW_W, BPC),
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [BPC-1:0]    i_bits,
  input  logic [CNT_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_sum
);

  localparam int NPOS = NCH * BPC;
  localparam int KW   = $clog2(NPOS + 1);

  logic [DATA_W-1:0] w_wtab [0:NPOS];
  logic [KW-1:0]     w_k;

  for (genvar k = 0; k <= NPOS; k++) begin : g_wtab
    assign w_wtab[k] = DATA_W'(nbcac_weight(k, CW_W));
  end

  // Add the weight of every set bit in the chunk, looked up by absolute position.
  always_comb begin
    o_sum = '0;
    w_k   = '0;
    for (int b = 0; b < BPC; b++) begin
      w_k = KW'(i_idx) * KW'(BPC) + KW'(b + 1);
      if (i_bits[b]) o_sum = o_sum + w_wtab[w_k];
    end
  end

endmodule

// File: rtl/nbcac_iter_decoder.sv
// Multi-cycle NBCAC decoder: captures a codeword, accumulates BPC bits of
// weighted sum per cycle over NCH cycles, then holds the result until taken.
// Optional forbidden-pattern check enabled by defining NBCAC_FPF_CHECK_EN.
module nbcac_iter_decoder
  import nbcac_pkg::*;
#(
  parameter int CW_W   = 33,
  parameter int DATA_W = 23,
  parameter int BPC    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int NCH   = nbcac_cdiv(CW_W, BPC);
  localparam int NPOS  = NCH * BPC;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  nbcac_dec_state_t  r_state;
  nbcac_dec_state_t  w_state_nxt;
  logic [NPOS-1:0]   r_cw;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_last;
  logic [BPC-1:0]    w_chunk;
  logic [DATA_W-1:0] w_sum;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CNT_W'(NCH - 1));
  assign w_chunk  = r_cw[r_cnt * BPC +: BPC];
  assign out_data = r_acc;

  nbcac_chunk_sum #(
    .CW_W  (CW_W),
    .DATA_W(DATA_W),
    .BPC   (BPC)
  ) u_chunk_sum (
    .i_bits(w_chunk),
    .i_idx (r_cnt),
    .o_sum (w_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ACC;
      end
      ACC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Codeword capture, chunk counter and accumulator; all cleared on reset so
  // an in-flight codeword is dropped and out_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cw  <= NPOS'(in_cw);
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == ACC) begin
      r_acc <= r_acc + w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef NBCAC_FPF_CHECK_EN
  logic r_err;

  // Flags any window of three adjacent bits reading 010 or 101.
  function automatic logic fpf_check(input logic [CW_W-1:0] cw);
    for (int k = 0; k + 2 < CW_W; k++) begin
      if ((cw[k+1] != cw[k]) && (cw[k+1] != cw[k+2])) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Pattern flag captured together with the codeword.
  always_ff @(posedge clk) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= fpf_check(in_cw);
  end

  assign out_err = r_err & out_valid;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_nbcac_iter_decoder.sv
// Self-checking bench for nbcac_iter_decoder: default configuration plus a
// small CW_W=10 / DATA_W=8 / BPC=3 instance, against a whole-word reference sum.
module tb_nbcac_iter_decoder;

  localparam int CW_W   = 33;
  localparam int DATA_W = 23;
  localparam int BPC    = 4;
  localparam int NCH    = 9;
  localparam int S_CW_W   = 10;
  localparam int S_DATA_W = 8;
  localparam int S_BPC    = 3;
  localparam int S_NCH    = 4;
`ifdef NBCAC_FPF_CHECK_EN
  localparam bit FPF = 1'b1;
`else
  localparam bit FPF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  logic                s_rst = 1'b1;
  logic                s_in_valid = 1'b0;
  logic                s_in_ready;
  logic [S_CW_W-1:0]   s_in_cw = '0;
  logic                s_out_valid;
  logic                s_out_ready = 1'b0;
  logic [S_DATA_W-1:0] s_out_data;
  logic                s_out_err;

  int n_vec = 0;
  int n_bad = 0;

  nbcac_iter_decoder #(.CW_W(CW_W), .DATA_W(DATA_W), .BPC(BPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  nbcac_iter_decoder #(.CW_W(S_CW_W), .DATA_W(S_DATA_W), .BPC(S_BPC)) dut_s (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_cw(s_in_cw),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_err(s_out_err)
  );

  // Reference: build the full weight table from the recurrence and sum all set bits.
  function automatic longint unsigned ref_decode(input logic [63:0] cw, input int n, input int dw);
    longint unsigned w [0:65];
    longint unsigned s;
    s = 0;
    w[n] = 2;
    w[n-1] = 2;
    for (int k = n - 2; k >= 2; k--) w[k] = w[k+1] + w[k+2];
    w[1] = 1;
    for (int k = 1; k <= n; k++) if (cw[k-1]) s += w[k];
    return s & ((64'd1 << dw) - 1);
  endfunction

  function automatic bit ref_err(input logic [63:0] cw, input int n);
    if (!FPF) return 1'b0;
    for (int k = 0; k + 2 < n; k++)
      if (cw[k] == cw[k+2] && cw[k] != cw[k+1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [CW_W-1:0] rand_cw();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CW_W-1:0];
  endfunction

  // One full transaction on the default instance with latency/data/flag checks.
  task automatic run_cw(input logic [CW_W-1:0] cw, input logic [DATA_W-1:0] exp_d,
                        input bit exp_e, input string name);
    int n;
    in_cw = cw;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cw = rand_cw();
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!out_valid && n > 2) in_cw = rand_cw();
    end while (!out_valid && n < 50);
    n_vec++;
    if (n != NCH) begin
      n_bad++; $display("FAIL %s_latency: got %0d cycles required %0d", name, n, NCH);
    end
    n_vec++;
    if (out_data !== exp_d) begin
      n_bad++; $display("FAIL %s_data: got %0d required %0d", name, out_data, exp_d);
    end
    n_vec++;
    if (out_err !== exp_e) begin
      n_bad++; $display("FAIL %s_err: got %b required %b", name, out_err, exp_e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    in_cw = rand_cw(); in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; s_rst = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset: valid=%b data=%0d err=%b ready=%b required 0/0/0/1",
                        out_valid, out_data, out_err, in_ready);
    end
    n_vec++;
    if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_small: valid=%b data=%0d ready=%b required 0/0/1",
                        s_out_valid, s_out_data, s_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [CW_W-1:0] cw;
    run_cw('0, 23'd0, 1'b0, "zero");
    cw = '0; cw[0] = 1'b1;
    run_cw(cw, 23'd1, 1'b0, "d1");
    cw = '0; cw[32] = 1'b1;
    run_cw(cw, 23'd2, 1'b0, "d33");
    cw = '0; cw[1] = 1'b1;
    run_cw(cw, 23'd4356618, FPF, "d2");
    cw = '0; cw[1] = 1'b1; cw[2] = 1'b1;
    run_cw(cw, 23'd7049156, 1'b0, "d2d3");
  endtask

  task automatic test_random();
    logic [CW_W-1:0] cw;
    for (int i = 0; i < 25; i++) begin
      cw = rand_cw();
      run_cw(cw, DATA_W'(ref_decode(64'(cw), CW_W, DATA_W)), ref_err(64'(cw), CW_W), "rand");
    end
  endtask

  task automatic test_small();
    logic [S_CW_W-1:0] cw;
    logic [S_DATA_W-1:0] exp_d;
    bit exp_e;
    int n;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        cw = '1; exp_d = 8'd177; exp_e = 1'b0;
      end else begin
        cw = S_CW_W'($urandom);
        exp_d = S_DATA_W'(ref_decode(64'(cw), S_CW_W, S_DATA_W));
        exp_e = ref_err(64'(cw), S_CW_W);
      end
      s_in_cw = cw; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_in_cw = S_CW_W'($urandom);
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!s_out_valid && n < 50);
      n_vec++;
      if (n != S_NCH) begin
        n_bad++; $display("FAIL small_latency: got %0d required %0d", n, S_NCH);
      end
      n_vec++;
      if (s_out_data !== exp_d || s_out_err !== exp_e) begin
        n_bad++; $display("FAIL small_data: got %0d/%b required %0d/%b", s_out_data, s_out_err, exp_d, exp_e);
      end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [CW_W-1:0] cw1, cw2;
    logic [DATA_W-1:0] e1, e2;
    int n;
    cw1 = rand_cw(); cw2 = rand_cw();
    e1 = DATA_W'(ref_decode(64'(cw1), CW_W, DATA_W));
    e2 = DATA_W'(ref_decode(64'(cw2), CW_W, DATA_W));
    in_cw = cw1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 50);
    in_cw = cw2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== e1 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold: valid=%b data=%0d ready=%b required 1/%0d/0",
                          out_valid, out_data, in_ready, e1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_idle: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 50);
    n_vec++;
    if (n != NCH || out_data !== e2) begin
      n_bad++; $display("FAIL bp_second: got %0d after %0d cycles required %0d after %0d",
                        out_data, n, e2, NCH);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_acc();
    logic [CW_W-1:0] cw;
    in_cw = rand_cw() | 33'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || out_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_acc: valid=%b data=%0d ready=%b err=%b required 0/0/1/0",
                        out_valid, out_data, in_ready, out_err);
    end
    cw = rand_cw();
    run_cw(cw, DATA_W'(ref_decode(64'(cw), CW_W, DATA_W)), ref_err(64'(cw), CW_W), "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_small();
    test_back_to_back();
    test_reset_mid_acc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
